// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    // Oversampling ticks per serial bit (power of two, 8 or 16)
    localparam int OVS_DEFAULT = 16;

    // Word-length field encodings from the line-control register
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Transmit FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_t;

    // Number of data bits carried by a frame for a given word-length code
    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        data_bits = 4'd8;
        case (wls)
            WLS_5: data_bits = 4'd5;
            WLS_6: data_bits = 4'd6;
            WLS_7: data_bits = 4'd7;
            WLS_8: data_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Per-frame data holder: loads one byte from the FIFO, shifts it out LSB
// first, and latches the line-control fields plus the parity bit so that
// register writes during a frame cannot disturb it.
module uart_tx_shift
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    output logic       data_bit,
    output logic       next_bit,
    output logic       parity,
    output logic [1:0] wls_q,
    output logic       stb_q,
    output logic       pen_q
);

    logic [7:0] sreg;
    logic [7:0] mask;
    logic       ones_odd;

    // Parity covers only the bits that will actually be sent
    always_comb begin
        mask     = 8'hFF >> (4'd8 - data_bits(wls));
        ones_odd = ^(din & mask);
    end

    // Load a new word and its config on LOAD, otherwise shift one bit per data bit
    // NOTE: these datapath registers carry no reset; LOAD always writes them before the FSM reads them.
    always_ff @(posedge clk) begin
        if (load) begin
            sreg   <= din;
            wls_q  <= wls;
            stb_q  <= stb;
            pen_q  <= pen;
            parity <= eps ? ones_odd : ~ones_odd;
        end else if (shift) begin
            sreg <= {1'b0, sreg[7:1]};
        end
    end

    assign data_bit = sreg[0];
    assign next_bit = sreg[1];

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and drives the
// registered serial line with start, data, optional parity and stop bits,
// timed by the shared 16x baud tick.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int OVS = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick16,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       brk,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic       temt,
    output logic       frame_done
);

    localparam int            TW        = $clog2(OVS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;

    logic in_frame;
    logic bit_end;
    logic last_data;
    logic last_stop;
    logic line_next;
    logic done_next;
    logic load;
    logic shift;

    logic       data_bit;
    logic       next_bit;
    logic       parity;
    logic [1:0] wls_q;
    logic       stb_q;
    logic       pen_q;

    uart_tx_shift u_shift (
        .clk      (clk),
        .load     (load),
        .shift    (shift),
        .din      (fifo_dout),
        .wls      (wls),
        .stb      (stb),
        .pen      (pen),
        .eps      (eps),
        .data_bit (data_bit),
        .next_bit (next_bit),
        .parity   (parity),
        .wls_q    (wls_q),
        .stb_q    (stb_q),
        .pen_q    (pen_q)
    );

    // Ticks only count while a bit is on the line; a bit ends on its last tick
    assign in_frame  = state inside {S_START, S_DATA, S_PARITY, S_STOP};
    assign bit_end   = in_frame && tick16 && (tick_cnt == TICK_LAST);
    assign last_data = (bit_cnt == 3'(data_bits(wls_q) - 4'd1));
    assign last_stop = (bit_cnt == {2'b00, stb_q});

    assign fifo_pop = (state == S_POP);
    assign busy     = (state != S_IDLE);
    assign temt     = fifo_empty & ~busy;

    // Next state and the line level the state being entered will present
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        line_next  = 1'b1;
        done_next  = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && !fifo_empty && !brk) state_next = S_POP;
            end
            S_POP: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                load       = 1'b1;
                state_next = S_START;
                line_next  = 1'b0;
            end
            S_START: begin
                line_next = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                    line_next  = data_bit;
                end
            end
            S_DATA: begin
                line_next = data_bit;
                if (bit_end) begin
                    if (last_data) begin
                        state_next = pen_q ? S_PARITY : S_STOP;
                        line_next  = pen_q ? parity : 1'b1;
                    end else begin
                        shift     = 1'b1;
                        line_next = next_bit;
                    end
                end
            end
            S_PARITY: begin
                line_next = parity;
                if (bit_end) begin
                    state_next = S_STOP;
                    line_next  = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end && last_stop) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, serial line and end-of-frame pulse; break overrides the line level
    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= brk ? 1'b0 : line_next;
            frame_done <= done_next;
        end
    end

    // Tick counter restarts on every state entry and at each bit boundary;
    // bit counter restarts on state entry and advances per completed bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if ((state_next != state) || !in_frame || bit_end) begin
                tick_cnt <= '0;
            end else if (tick16) begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a table of single frames with
// hand-computed bit sequences, then hand-written multi-cycle sequences for
// back-to-back frames, reset mid-frame, enable drop and break.
module tb_uart_tx_engine;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick16 = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       brk = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic       temt;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.OVS(OVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick16     (tick16),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .brk        (brk),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .temt       (temt),
        .frame_done (frame_done)
    );

    // Small FIFO model: registered read data, pops suppressed when empty
    logic [7:0] fifo_mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int done_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pop && (wr_ptr != rd_ptr)) begin
            fifo_dout <= fifo_mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_pop) pop_cnt <= pop_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        pen;
        logic        eps;
        logic        stb;
        logic [11:0] bits;   // bit i = line level during serial bit i
        int          nbits;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_tx_low(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " start seen"}, 32'(tx === 1'b0), 1);
    endtask

    // Entered on the first negedge of START; leaves one negedge after frame_done
    task automatic check_frame(input string name, input logic [11:0] bits, input int nbits);
        int bad_bit = -1;
        int bad_done = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < OVS; c++) begin
                if (tx !== bits[i] && bad_bit < 0) bad_bit = i;
                if (frame_done !== 1'b0) bad_done++;
                @(negedge clk);
            end
        end
        check({name, " first wrong bit"}, bad_bit, -1);
        check({name, " early frame_done"}, bad_done, 0);
        check({name, " frame_done"}, 32'(frame_done), 1);
        check({name, " idle high"}, 32'(tx), 1);
        check({name, " busy clear"}, 32'(busy), 0);
        @(negedge clk);
        check({name, " frame_done width"}, 32'(frame_done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int d0;
        int n;
        int bad;

        //            data   wls    pen   eps   stb   bits (i=0 is start)   nbits
        vecs[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 12'b0010_1010_1010, 10}; // 8N1
        vecs[1] = '{8'hA3, 2'b10, 1'b1, 1'b1, 1'b1, 12'b0111_0100_0110, 11}; // 7E2
        vecs[2] = '{8'hA3, 2'b10, 1'b1, 1'b0, 1'b1, 12'b0110_0100_0110, 11}; // 7O2
        vecs[3] = '{8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 12'b0000_1111_1110,  8}; // 5E1
        vecs[4] = '{8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 12'b0001_0101_0100,  9}; // 6O1
        vecs[5] = '{8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 12'b0110_0000_0000, 11}; // 8O1

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 1);
        check("reset busy", 32'(busy), 0);
        check("reset fifo_pop", 32'(fifo_pop), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset temt", 32'(temt), 1);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        check("idle tx", 32'(tx), 1);

        // Single frames; config is scrambled once the frame starts
        for (int v = 0; v < 6; v++) begin
            wls = vecs[v].wls;
            pen = vecs[v].pen;
            eps = vecs[v].eps;
            stb = vecs[v].stb;
            p0  = pop_cnt;
            push(vecs[v].data);
            wait_tx_low($sformatf("vec%0d", v));
            wls = ~vecs[v].wls;
            pen = ~vecs[v].pen;
            eps = ~vecs[v].eps;
            stb = ~vecs[v].stb;
            check_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].nbits);
            check($sformatf("vec%0d pops", v), pop_cnt - p0, 1);
            check($sformatf("vec%0d temt", v), 32'(temt), 1);
        end

        // Back-to-back 0x01, 0x80 in 8N1
        wls = 2'b11; pen = 1'b0; eps = 1'b0; stb = 1'b0;
        p0 = pop_cnt;
        d0 = done_cnt;
        push(8'h01);
        push(8'h80);
        wait_tx_low("b2b first");
        check_frame("b2b first", 12'b0010_0000_0010, 10);
        n = 0;
        while (tx === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("b2b idle gap", n + 1, 3);
        check_frame("b2b second", 12'b0011_0000_0000, 10);
        check("b2b pops", pop_cnt - p0, 2);
        check("b2b frame_done count", done_cnt - d0, 2);

        // Reset in the middle of data bit 3 of 0xF0
        p0 = pop_cnt;
        push(8'hF0);
        wait_tx_low("rst frame");
        repeat (OVS + 3 * OVS + 5) @(negedge clk);
        check("rst pre bit3 low", 32'(tx), 0);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst tx high", 32'(tx), 1);
        check("rst busy", 32'(busy), 0);
        check("rst frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst pops", pop_cnt - p0, 1);
        check("rst no frame_done", done_cnt - d0, 0);
        check("rst idle tx", 32'(tx), 1);

        // Enable dropped during START of 0x3C with 0x99 queued behind it
        p0 = pop_cnt;
        push(8'h3C);
        push(8'h99);
        wait_tx_low("en frame");
        en = 1'b0;
        check_frame("en frame", 12'b0010_0111_1000, 10);
        repeat (50) @(negedge clk);
        check("en held pops", pop_cnt - p0, 1);
        check("en held busy", 32'(busy), 0);
        check("en held temt", 32'(temt), 0);
        en = 1'b1;
        wait_tx_low("en resume");
        check_frame("en resume", 12'b0011_0011_0010, 10);
        check("en resume pops", pop_cnt - p0, 2);

        // Break held in IDLE with data waiting
        p0 = pop_cnt;
        brk = 1'b1;
        push(8'h55);
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (tx !== 1'b0) bad++;
            @(negedge clk);
        end
        check("brk tx low cycles", bad, 0);
        check("brk no pop", pop_cnt - p0, 0);
        check("brk busy", 32'(busy), 0);
        brk = 1'b0;
        @(negedge clk);
        check("brk release tx", 32'(tx), 1);
        wait_tx_low("brk frame");
        check_frame("brk frame", 12'b0010_1010_1010, 10);
        check("brk frame pops", pop_cnt - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
